// File: rtl/dot_row_accum.sv
// Row accumulator for the dot8 pipeline: sums partial products per row and queues
// completed rows in a show-ahead FIFO; never stalls the producer, drops rows when full.
module dot_row_accum #(
    parameter int unsigned IWIDTH     = 32,
    parameter int unsigned OWIDTH     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IWIDTH-1:0]               idata,
    input  logic                            ivalid,
    input  logic                            ilast,
    output logic [OWIDTH-1:0]               result,
    output logic                            ovalid,
    input  logic                            oready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy,
    output logic                            overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [OWIDTH-1:0] acc_q, acc_d;
    logic              first_q, first_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              overflow_q, overflow_d;
    logic              ovalid_q, ovalid_d;
    logic [OWIDTH-1:0] result_q, result_d;
    logic [OWIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [OWIDTH-1:0] sum_c;
    logic              push_c;
    logic              pop_c;
    logic              full_c;
    logic              wr_en_c;
    logic              head_from_push_c;

    // Sign-extended partial product added to the running sum (wraps at OWIDTH).
    assign sum_c  = (first_q ? OWIDTH'(0) : acc_q) + OWIDTH'($signed(idata));
    assign push_c = ivalid & ilast;
    assign pop_c  = ovalid_q & oready;
    assign full_c = (occ_q == OCC_W'(FIFO_DEPTH));
    // A pop frees the full slot in the same cycle, so push-at-full still lands.
    assign wr_en_c = push_c & (~full_c | pop_c);

    // New head comes straight from this push when the FIFO is (or becomes) otherwise empty.
    assign head_from_push_c = wr_en_c &
                              ((occ_q == OCC_W'(0)) | ((occ_q == OCC_W'(1)) & pop_c));

    always_comb begin
        acc_d      = acc_q;
        first_d    = first_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;
        ovalid_d   = 1'b0;
        result_d   = '0;

        if (ivalid) begin
            if (ilast) begin
                acc_d   = '0;
                first_d = 1'b1;
            end else begin
                acc_d   = sum_c;
                first_d = 1'b0;
            end
        end

        if (push_c && !wr_en_c) begin
            overflow_d = 1'b1;
        end

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        occ_d = occ_q + OCC_W'(wr_en_c) - OCC_W'(pop_c);

        if (occ_d != OCC_W'(0)) begin
            ovalid_d = 1'b1;
            result_d = head_from_push_c ? sum_c : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            first_q    <= 1'b1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            ovalid_q   <= 1'b0;
            result_q   <= '0;
        end else begin
            acc_q      <= acc_d;
            first_q    <= first_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            ovalid_q   <= ovalid_d;
            result_q   <= result_d;
        end
    end

    // Storage needs no reset: entries are only read once occupancy covers them.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= sum_c;
        end
    end

    assign result    = result_q;
    assign ovalid    = ovalid_q;
    assign occupancy = occ_q;
    assign overflow  = overflow_q;

endmodule
